// File: rtl/vgachargen_pkg.sv
// vgachargen_pkg: shared constants for the character generator.
// The text screen is 80 columns x 30 rows. The char/colour map address is
// {row[4:0], col[6:0]}. This package also holds the fill controller FSM state type.
package vgachargen_pkg;

  localparam int CH_H_PIXELS       = 80;  // character columns per row
  localparam int CH_V_PIXELS       = 30;  // character rows per screen
  localparam int CH_H_WIDTH        = 7;   // column field width in the map address
  localparam int CH_V_WIDTH        = 5;   // row field width in the map address
  localparam int CH_MAP_ADDR_WIDTH = CH_V_WIDTH + CH_H_WIDTH;
  localparam int CH_MAP_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // The row sits above the column, so each row starts on a 128-entry boundary.
  // Columns 80..127 of every row are holes that nothing ever writes.
  function automatic logic [CH_MAP_ADDR_WIDTH-1:0] ch_map_addr(
    input logic [CH_V_WIDTH-1:0] row,
    input logic [CH_H_WIDTH-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/vgachargen_fill_ctrl_if.sv
// vgachargen_fill_ctrl_if: bundles the fill controller's command, CPU and
// memory-write signals. The bench uses it to drive and observe one controller.
//   master: the side that issues commands and CPU writes and observes mem_*.
//   slave : the controller side.
// Handshake: a fill command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ch and cmd_col must be stable while cmd_valid is
// high. cpu_gnt follows cpu_req in the same cycle, so a CPU write is never held off.
interface vgachargen_fill_ctrl_if;
  import vgachargen_pkg::*;

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [CH_MAP_DATA_WIDTH-1:0] cmd_ch;
  logic [CH_MAP_DATA_WIDTH-1:0] cmd_col;
  logic                         abort;
  logic                         vblank;
  logic                         cpu_req;
  logic [CH_MAP_ADDR_WIDTH-1:0] cpu_addr;
  logic [CH_MAP_DATA_WIDTH-1:0] cpu_ch;
  logic [CH_MAP_DATA_WIDTH-1:0] cpu_col;
  logic                         cpu_gnt;
  logic                         mem_we;
  logic [CH_MAP_ADDR_WIDTH-1:0] mem_addr;
  logic [CH_MAP_DATA_WIDTH-1:0] mem_ch;
  logic [CH_MAP_DATA_WIDTH-1:0] mem_col;
  logic                         busy;
  logic                         done;

  modport master (
    output cmd_valid, cmd_ch, cmd_col, abort, vblank,
           cpu_req, cpu_addr, cpu_ch, cpu_col,
    input  cmd_ready, cpu_gnt, mem_we, mem_addr, mem_ch, mem_col, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_col, abort, vblank,
           cpu_req, cpu_addr, cpu_ch, cpu_col,
    output cmd_ready, cpu_gnt, mem_we, mem_addr, mem_ch, mem_col, busy, done
  );

endinterface

// File: rtl/vgachargen_fill_ctrl.sv
// vgachargen_fill_ctrl: fills the whole character and colour map with one
// {char, colour} pair. It shares the single map write port with a CPU
// requester, and the CPU always has priority.
// Ports:
//   clk_i, rst_ni                     clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o           fill command handshake (ready = idle)
//   cmd_ch_i, cmd_col_i               fill character and {fg,bg} colour
//   abort_i                           cancels an active fill
//   vblank_i                          vertical blank; gates fill writes if WAIT_VBLANK
//   cpu_req_i/cpu_addr_i/cpu_ch_i/cpu_col_i, cpu_gnt_o   CPU single writes
//   mem_we_o/mem_addr_o/mem_ch_o/mem_col_o              registered map write port
//   busy_o, done_o                    fill active, one-cycle completion pulse
//   state_o                           current FSM state (debug)
module vgachargen_fill_ctrl
  import vgachargen_pkg::*;
#(
  parameter bit WAIT_VBLANK = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [CH_MAP_DATA_WIDTH-1:0] cmd_ch_i,
  input  logic [CH_MAP_DATA_WIDTH-1:0] cmd_col_i,
  input  logic                         abort_i,
  input  logic                         vblank_i,
  input  logic                         cpu_req_i,
  input  logic [CH_MAP_ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [CH_MAP_DATA_WIDTH-1:0] cpu_ch_i,
  input  logic [CH_MAP_DATA_WIDTH-1:0] cpu_col_i,
  output logic                         cpu_gnt_o,
  output logic                         mem_we_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0] mem_ch_o,
  output logic [CH_MAP_DATA_WIDTH-1:0] mem_col_o,
  output logic                         busy_o,
  output logic                         done_o,
  output fill_state_t                  state_o
);

  localparam logic [CH_H_WIDTH-1:0] COL_LAST = CH_H_WIDTH'(CH_H_PIXELS - 1);
  localparam logic [CH_V_WIDTH-1:0] ROW_LAST = CH_V_WIDTH'(CH_V_PIXELS - 1);

  fill_state_t                  state_q, state_d;
  logic [CH_V_WIDTH-1:0]        row_q;
  logic [CH_H_WIDTH-1:0]        col_q;
  logic [CH_MAP_DATA_WIDTH-1:0] fill_ch_q;
  logic [CH_MAP_DATA_WIDTH-1:0] fill_col_q;
  logic                         cmd_acc;
  logic                         fill_we;
  logic                         col_last;
  logic                         at_end;

  assign cmd_acc  = cmd_valid_i && (state_q == IDLE);
  // A fill write goes ahead only when the CPU leaves the port free.
  // An abort in the same cycle suppresses it, even on the final address.
  assign fill_we  = (state_q == FILL) && !abort_i && (!WAIT_VBLANK || vblank_i)
                    && !cpu_req_i;
  assign col_last = (col_q == COL_LAST);
  assign at_end   = col_last && (row_q == ROW_LAST);
  assign cpu_gnt_o = cpu_req_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid_i) state_d = FILL;
      FILL: begin
        if (abort_i)                state_d = IDLE;
        else if (fill_we && at_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_ready_o = (state_q == IDLE);
    busy_o      = (state_q == FILL);
    state_o     = state_q;
  end

  // Row/column walker and latched fill data. The counters move only on a real
  // fill write, so CPU-won and vblank-gated cycles leave the position unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_q      <= '0;
      col_q      <= '0;
      fill_ch_q  <= '0;
      fill_col_q <= '0;
    end else if (cmd_acc) begin
      row_q      <= '0;
      col_q      <= '0;
      fill_ch_q  <= cmd_ch_i;
      fill_col_q <= cmd_col_i;
    end else if (fill_we) begin
      if (at_end) begin
        row_q <= '0;
        col_q <= '0;
      end else if (col_last) begin
        row_q <= row_q + CH_V_WIDTH'(1);
        col_q <= '0;
      end else begin
        col_q <= col_q + CH_H_WIDTH'(1);
      end
    end
  end

  // Registered write port. Address and data keep their last values when idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_ch_o   <= '0;
      mem_col_o  <= '0;
      done_o     <= 1'b0;
    end else begin
      mem_we_o <= cpu_req_i || fill_we;
      done_o   <= fill_we && at_end;
      if (cpu_req_i) begin
        mem_addr_o <= cpu_addr_i;
        mem_ch_o   <= cpu_ch_i;
        mem_col_o  <= cpu_col_i;
      end else if (fill_we) begin
        mem_addr_o <= ch_map_addr(row_q, col_q);
        mem_ch_o   <= fill_ch_q;
        mem_col_o  <= fill_col_q;
      end
    end
  end

endmodule

// File: tb/tb_vgachargen_fill_ctrl.sv
// tb_vgachargen_fill_ctrl: directed bench for vgachargen_fill_ctrl.
// u_dut uses the default WAIT_VBLANK=0 and u_dut_vb uses WAIT_VBLANK=1.
// Fill addresses observed on mem_* are compared with an expected queue built
// from the screen geometry.
module tb_vgachargen_fill_ctrl;
  import vgachargen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vgachargen_fill_ctrl_if a_if ();
  vgachargen_fill_ctrl_if b_if ();
  fill_state_t a_state, b_state;

  vgachargen_fill_ctrl u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(a_if.cmd_valid), .cmd_ready_o(a_if.cmd_ready),
    .cmd_ch_i(a_if.cmd_ch), .cmd_col_i(a_if.cmd_col),
    .abort_i(a_if.abort), .vblank_i(a_if.vblank),
    .cpu_req_i(a_if.cpu_req), .cpu_addr_i(a_if.cpu_addr),
    .cpu_ch_i(a_if.cpu_ch), .cpu_col_i(a_if.cpu_col), .cpu_gnt_o(a_if.cpu_gnt),
    .mem_we_o(a_if.mem_we), .mem_addr_o(a_if.mem_addr),
    .mem_ch_o(a_if.mem_ch), .mem_col_o(a_if.mem_col),
    .busy_o(a_if.busy), .done_o(a_if.done), .state_o(a_state)
  );

  vgachargen_fill_ctrl #(.WAIT_VBLANK(1'b1)) u_dut_vb (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(b_if.cmd_valid), .cmd_ready_o(b_if.cmd_ready),
    .cmd_ch_i(b_if.cmd_ch), .cmd_col_i(b_if.cmd_col),
    .abort_i(b_if.abort), .vblank_i(b_if.vblank),
    .cpu_req_i(b_if.cpu_req), .cpu_addr_i(b_if.cpu_addr),
    .cpu_ch_i(b_if.cpu_ch), .cpu_col_i(b_if.cpu_col), .cpu_gnt_o(b_if.cpu_gnt),
    .mem_we_o(b_if.mem_we), .mem_addr_o(b_if.mem_addr),
    .mem_ch_o(b_if.mem_ch), .mem_col_o(b_if.mem_col),
    .busy_o(b_if.busy), .done_o(b_if.done), .state_o(b_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Scoreboard state
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  logic [11:0] a_act_q[$];
  logic [11:0] b_act_q[$];
  logic [7:0]  exp_ch, exp_col;
  int a_cpu_wr, a_cpu_bad, a_data_bad, a_done, a_done_bad, a_busy, a_gnt;
  int b_gate_bad, b_done, b_done_bad;
  logic        a_cpu_seen, b_vb_seen;
  logic [11:0] a_cpu_addr_seen;
  logic [7:0]  a_cpu_ch_seen, a_cpu_col_seen;

  // Inputs as they were during the cycle that just ended
  always @(posedge clk) begin
    a_cpu_seen      <= a_if.cpu_req;
    a_cpu_addr_seen <= a_if.cpu_addr;
    a_cpu_ch_seen   <= a_if.cpu_ch;
    a_cpu_col_seen  <= a_if.cpu_col;
    b_vb_seen       <= b_if.vblank;
  end

  // Write-port monitors
  always @(negedge clk) begin
    if (a_if.mem_we) begin
      if (a_cpu_seen) begin
        a_cpu_wr++;
        if (a_if.mem_addr != a_cpu_addr_seen || a_if.mem_ch != a_cpu_ch_seen ||
            a_if.mem_col != a_cpu_col_seen) a_cpu_bad++;
      end else begin
        a_act_q.push_back(a_if.mem_addr);
        if (a_if.mem_ch != exp_ch || a_if.mem_col != exp_col) a_data_bad++;
      end
    end
    if (a_if.done) begin
      a_done++;
      if (!(a_if.mem_we && a_if.mem_addr == 12'hECF)) a_done_bad++;
    end
    if (a_if.busy)    a_busy++;
    if (a_if.cpu_gnt) a_gnt++;
    if (b_if.mem_we) begin
      b_act_q.push_back(b_if.mem_addr);
      if (!b_vb_seen) b_gate_bad++;
    end
    if (b_if.done) begin
      b_done++;
      if (!(b_if.mem_we && b_if.mem_addr == 12'hECF)) b_done_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1;
    a_act_q.delete(); b_act_q.delete();
    a_cpu_wr = 0; a_cpu_bad = 0; a_data_bad = 0; a_done = 0; a_done_bad = 0;
    a_busy = 0; a_gnt = 0; b_gate_bad = 0; b_done = 0; b_done_bad = 0;
  endtask

  // Returns 1 ns after the accepting edge, in the first FILL cycle.
  task automatic send_cmd_a(input logic [7:0] ch, input logic [7:0] col);
    @(posedge clk); #1;
    exp_ch = ch; exp_col = col;
    a_if.cmd_valid = 1'b1; a_if.cmd_ch = ch; a_if.cmd_col = col;
    @(posedge clk); #1;
    a_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag, input int budget);
    int n = 0;
    while (a_if.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, n >= budget}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Compares obs_q against the first n addresses of the row-major walk.
  task automatic cmp_fill(input string tag, input int n);
    int errs = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(12'(((i / 80) << 7) | (i % 80)));
    check({tag, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) errs++;
    check({tag, "_order"}, errs, 0);
  endtask

  initial begin
    int cyc;
    int ecf_hits;
    a_if.cmd_valid = 0; a_if.cmd_ch = 0; a_if.cmd_col = 0; a_if.abort = 0;
    a_if.vblank = 0; a_if.cpu_req = 0; a_if.cpu_addr = 0; a_if.cpu_ch = 0; a_if.cpu_col = 0;
    b_if.cmd_valid = 0; b_if.cmd_ch = 0; b_if.cmd_col = 0; b_if.abort = 0;
    b_if.vblank = 0; b_if.cpu_req = 0; b_if.cpu_addr = 0; b_if.cpu_ch = 0; b_if.cpu_col = 0;
    exp_ch = 0; exp_col = 0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_we", a_if.mem_we, 0);
    check("rst_mem_addr", a_if.mem_addr, 0);
    check("rst_mem_ch", a_if.mem_ch, 0);
    check("rst_mem_col", a_if.mem_col, 0);
    check("rst_done", a_if.done, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_state", a_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", a_if.cmd_ready, 1);

    // Full uncontended fill
    clear_mon();
    send_cmd_a(8'h41, 8'hF0);
    check("fill_busy_start", a_if.busy, 1);
    check("fill_ready_low", a_if.cmd_ready, 0);
    wait_idle_a("fill1_timeout", 3000);
    obs_q = a_act_q;
    cmp_fill("fill1", 2400);
    check("fill1_first", obs_q[0], 12'h000);
    check("fill1_81st", obs_q[80], 12'h080);
    check("fill1_last", obs_q[2399], 12'hECF);
    check("fill1_done_cnt", a_done, 1);
    check("fill1_done_align", a_done_bad, 0);
    check("fill1_busy_cycles", a_busy, 2400);
    check("fill1_data", a_data_bad, 0);

    // CPU contention plus an ignored command mid-fill
    clear_mon();
    send_cmd_a(8'h12, 8'h34);
    repeat (50) @(posedge clk); #1;
    a_if.cpu_req = 1; a_if.cpu_addr = 12'h123; a_if.cpu_ch = 8'h55; a_if.cpu_col = 8'h66;
    @(negedge clk);
    check("cpu_gnt_fill", a_if.cpu_gnt, 1);
    @(posedge clk); #1;
    a_if.cmd_valid = 1; a_if.cmd_ch = 8'hAA; a_if.cmd_col = 8'hBB;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_if.cpu_req = 0; a_if.cmd_valid = 0;
    wait_idle_a("fill2_timeout", 3000);
    obs_q = a_act_q;
    cmp_fill("fill2", 2400);
    check("cpu_gnt_cycles", a_gnt, 3);
    check("cpu_writes", a_cpu_wr, 3);
    check("cpu_write_data", a_cpu_bad, 0);
    check("fill2_latched_data", a_data_bad, 0);
    check("fill2_done_cnt", a_done, 1);
    @(posedge clk); #1;
    a_if.cpu_req = 1; a_if.cpu_addr = 12'h7FF;
    @(negedge clk);
    check("cpu_gnt_idle", a_if.cpu_gnt, 1);
    @(posedge clk); #1;
    a_if.cpu_req = 0;

    // Abort ignored in IDLE, then abort after 100 fill writes
    clear_mon();
    a_if.abort = 1;
    @(negedge clk);
    check("abort_idle_ready", a_if.cmd_ready, 1);
    @(posedge clk); #1;
    a_if.abort = 0;
    check("abort_idle_state", a_state, IDLE);
    send_cmd_a(8'h41, 8'hF0);
    repeat (100) @(posedge clk); #1;
    a_if.abort = 1;
    @(posedge clk); #1;
    a_if.abort = 0;
    check("abort_ready", a_if.cmd_ready, 1);
    check("abort_busy", a_if.busy, 0);
    repeat (5) @(negedge clk);
    obs_q = a_act_q;
    cmp_fill("abort100", 100);
    check("abort_no_done", a_done, 0);
    clear_mon();
    send_cmd_a(8'h07, 8'h1E);
    wait_idle_a("fill3_timeout", 3000);
    obs_q = a_act_q;
    cmp_fill("fill3", 2400);
    check("fill3_first", obs_q[0], 12'h000);
    check("fill3_done_cnt", a_done, 1);

    // Reset mid-fill
    clear_mon();
    send_cmd_a(8'h33, 8'h44);
    repeat (200) @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_we", a_if.mem_we, 0);
    check("mid_rst_addr", a_if.mem_addr, 0);
    check("mid_rst_ch", a_if.mem_ch, 0);
    check("mid_rst_col", a_if.mem_col, 0);
    check("mid_rst_busy", a_if.busy, 0);
    check("mid_rst_done", a_if.done, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("mid_rst_ready", a_if.cmd_ready, 1);
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", a_done, 0);
    clear_mon();
    send_cmd_a(8'h5A, 8'hA5);
    wait_idle_a("fill4_timeout", 3000);
    obs_q = a_act_q;
    cmp_fill("fill4", 2400);
    check("fill4_data", a_data_bad, 0);
    check("fill4_done_cnt", a_done, 1);

    // Abort coinciding with the final address
    clear_mon();
    send_cmd_a(8'h41, 8'hF0);
    repeat (2399) @(posedge clk); #1;
    a_if.abort = 1;
    @(posedge clk); #1;
    a_if.abort = 0;
    repeat (4) @(negedge clk);
    obs_q = a_act_q;
    cmp_fill("abort_last", 2399);
    ecf_hits = 0;
    foreach (obs_q[i]) if (obs_q[i] == 12'hECF) ecf_hits++;
    check("abort_last_no_ecf", ecf_hits, 0);
    check("abort_last_no_done", a_done, 0);
    check("abort_last_busy", a_if.busy, 0);
    check("abort_last_ready", a_if.cmd_ready, 1);

    // Vblank-gated fill: 10 cycles on, 20 off
    clear_mon();
    @(posedge clk); #1;
    b_if.cmd_valid = 1; b_if.cmd_ch = 8'h20; b_if.cmd_col = 8'h0F;
    @(posedge clk); #1;
    b_if.cmd_valid = 0;
    cyc = 0;
    while (b_if.busy && cyc < 9000) begin
      b_if.vblank = ((cyc % 30) < 10);
      @(posedge clk); #1;
      cyc++;
    end
    b_if.vblank = 0;
    repeat (3) @(negedge clk);
    check("vb_cycles", cyc, 7180);
    obs_q = b_act_q;
    cmp_fill("vb_fill", 2400);
    check("vb_gate", b_gate_bad, 0);
    check("vb_done_cnt", b_done, 1);
    check("vb_done_align", b_done_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vgachargen_fill_ctrl.md
VGACHARGEN_FILL_CTRL -- requirements
Module: vgachargen_fill_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_VBLANK, default 1'b0; when 1, fill writes are issued only while vblank_i=1.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1, reset: synchronous and active-low.
REQ-004 The block SHALL have ports cmd_valid_i (in, 1), cmd_ready_o (out, 1), cmd_ch_i (in, CH_MAP_DATA_WIDTH=8) and cmd_col_i (in, 8): the full-screen fill command with its character code and {fg,bg} colour nibbles.
REQ-005 The block SHALL have port abort_i, input, 1, which cancels an active fill.
REQ-006 The block SHALL have port vblank_i, input, 1, the vertical-blank indicator from the timing generator.
REQ-007 The block SHALL have ports cpu_req_i (in, 1), cpu_addr_i (in, CH_MAP_ADDR_WIDTH=12), cpu_ch_i (in, 8), cpu_col_i (in, 8) and cpu_gnt_o (out, 1): the bus-side single-write requester.
REQ-008 The block SHALL have ports mem_we_o (out, 1), mem_addr_o (out, 12), mem_ch_o (out, 8) and mem_col_o (out, 8): the shared write port to the char map and colour map.
REQ-009 The block SHALL have outputs busy_o (1), high in FILL, and done_o (1), a one-cycle pulse on fill completion.

Function
REQ-010 FSM states SHALL be IDLE and FILL only.
REQ-011 cmd_ready_o SHALL equal (state==IDLE); a command SHALL be accepted on cmd_valid_i && cmd_ready_o, latching cmd_ch_i/cmd_col_i, clearing row/col counters to 0, and entering FILL next cycle.
REQ-012 The address SHALL be {row[4:0], col[6:0]}; col SHALL count 0..CH_H_PIXELS-1 (79), then wrap to 0 and increment row, which counts 0..CH_V_PIXELS-1 (29); addresses with col>79 or row>29 SHALL never be written.
REQ-013 cpu_gnt_o SHALL equal cpu_req_i combinationally in every state; the CPU SHALL have strict priority and never stall.
REQ-014 Each cycle the write-port source SHALL be: CPU if cpu_req_i; else fill if state==FILL, !abort_i and (!WAIT_VBLANK || vblank_i); else none.
REQ-015 A fill write SHALL advance the counters; a CPU-won or vblank-gated cycle SHALL hold them.
REQ-016 mem_* SHALL be registered: the request selected in cycle t appears on mem_* in cycle t+1; mem_we_o=0 when there is no source, and the data/address outputs hold their last values.
REQ-017 The fill write at address 0xECF (row 29, col 79) SHALL return the FSM to IDLE; done_o SHALL be 1 in the same cycle that final write shows on mem_we_o.
REQ-018 abort_i in FILL SHALL return the FSM to IDLE next cycle with no fill write that cycle and no done_o; abort_i in IDLE SHALL be ignored.
REQ-019 If abort_i coincides with the final fill address, abort SHALL win: no write and no done_o.
REQ-020 cmd_valid_i during FILL SHALL be ignored (ready low) and SHALL not alter the latched data.
REQ-021 A full fill without contention or gating SHALL take exactly 2400 cycles from the FILL entry cycle.

Reset
REQ-022 While rst_ni=0 at a clock edge: state=IDLE, row=col=0, mem_we_o=0, mem_addr_o=0, mem_ch_o=0, mem_col_o=0, done_o=0, busy_o=0, latched data=0.
REQ-023 Reset mid-fill SHALL abandon the fill silently (no done_o); cmd_ready_o SHALL be 1 in the first cycle after release.

Structure
REQ-024 CH_H_PIXELS, CH_V_PIXELS, CH_H_WIDTH, CH_V_WIDTH, CH_MAP_ADDR_WIDTH and CH_MAP_DATA_WIDTH SHALL come from vgachargen_pkg; the FSM state enum SHALL be added there as fill_state_t.
REQ-025 The block SHALL be one module with no sub-modules; the row/col counter pair may be an internal always block but not a separate module.

Verification
REQ-026 Command ch=0x41, col=0xF0, no contention -> exactly 2400 mem_we_o pulses; first address 0x000, 81st address 0x080, last 0xECF; done_o coincides with the last write; busy_o high for 2400 cycles.
REQ-027 cpu_req_i held 3 cycles (addr 0x123, ch 0x55) mid-fill -> cpu_gnt_o high 3 cycles; mem_* shows the CPU writes; the fill resumes at the held address with none skipped; total fill writes still 2400.
REQ-028 WAIT_VBLANK=1 with vblank_i toggling 10 on / 20 off -> fill writes only in cycles after vblank_i=1; counters frozen otherwise; completion in order.
REQ-029 abort_i after 100 fill writes -> no further fill writes, no done_o, cmd_ready_o=1 next cycle; a new command restarts at address 0x000.
REQ-030 rst_ni=0 for 1 cycle mid-fill -> all outputs at reset values; no done_o; a subsequent command completes normally.
REQ-031 abort_i in the same cycle as address 0xECF -> no write to 0xECF and no done_o.
